// File: rtl/posit_sched_pkg.sv
// posit_sched_pkg
//   Shared types and helpers for the posit adder scheduler:
//   - sched_state_t : scheduler FSM states
//   - clog2()       : ceiling log2 for sizing counters and indices
//   - nar_word()    : posit NaR pattern (MSB set, rest zero) for a given width
package posit_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // NaR is a one followed by width-1 zeros; callers truncate to width.
  function automatic logic [63:0] nar_word(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker. Searches req starting one position
//   above ptr, wrapping at NREQ, and returns the first set bit.
//   Ports:
//     req   in  NREQ  pending requests
//     ptr   in  IW    last granted index (search starts at ptr+1)
//     grant out NREQ  one-hot grant (all zero when req is zero)
//     index out IW    binary index of the grant (zero when nothing granted)
module rr_arbiter
  import posit_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   index
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      // Candidate position (ptr + i) mod NREQ without a divider.
      if (int'(ptr) + i >= NREQ) begin
        cand = IW'(int'(ptr) + i - NREQ);
      end else begin
        cand = IW'(int'(ptr) + i);
      end
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/posit_add_sched.sv
// posit_add_sched
//   Shares one external posit adder among NREQ requesters in round-robin
//   order. One operand pair is accepted, held on the adder until done (or a
//   watchdog abort), and the result is returned to the granted requester.
//   Ports:
//     clk, rst_n                clock, asynchronous active-low reset
//     req_valid/req_a/req_b     per-requester request and packed operands
//     req_ready                 one-hot accept strobe (IDLE only)
//     rsp_valid                 one-hot, single-cycle response strobe
//     rsp_data/inf/zero/err     result; held until the next capture
//     add_in1/add_in2/add_start adder drive
//     add_out/inf/zero/done     adder result and handshake
module posit_add_sched
  import posit_sched_pkg::*;
#(
  parameter int N       = 8,
  parameter int es      = 2,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*N-1:0]  req_a,
  input  logic [NREQ*N-1:0]  req_b,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [N-1:0]       rsp_data,
  output logic               rsp_inf,
  output logic               rsp_zero,
  output logic               rsp_err,
  output logic [N-1:0]       add_in1,
  output logic [N-1:0]       add_in2,
  output logic               add_start,
  input  logic [N-1:0]       add_out,
  input  logic               add_inf,
  input  logic               add_zero,
  input  logic               add_done
);

  localparam int IW = clog2(NREQ);
  // Scheduling never looks at posit fields; es is carried with the instance
  // only so it matches the adder it fronts.
  localparam int CW = clog2(TIMEOUT + 1) + 0 * es;
  localparam logic [N-1:0] NAR = N'(nar_word(N));

  sched_state_t    state_reg;
  logic [IW-1:0]   ptr_reg;
  logic [IW-1:0]   gnt_idx_reg;
  logic [CW-1:0]   cnt_reg;
  logic [N-1:0]    op_a_reg;
  logic [N-1:0]    op_b_reg;
  logic            add_start_reg;
  logic [NREQ-1:0] rsp_valid_reg;
  logic [N-1:0]    rsp_data_reg;
  logic            rsp_inf_reg;
  logic            rsp_zero_reg;
  logic            rsp_err_reg;

  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_index;
  logic [N-1:0]    a_slice [NREQ];
  logic [N-1:0]    b_slice [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign a_slice[gi] = req_a[gi*N +: N];
      assign b_slice[gi] = req_b[gi*N +: N];
    end
  endgenerate

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (arb_grant),
    .index (arb_index)
  );

  // Accept strobe is combinational in IDLE; gating with rst_n keeps it low
  // for the whole time reset is held.
  assign req_ready = (state_reg == IDLE && rst_n) ? arb_grant : '0;

  assign add_start = add_start_reg;
  assign add_in1   = op_a_reg;
  assign add_in2   = op_b_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_inf   = rsp_inf_reg;
  assign rsp_zero  = rsp_zero_reg;
  assign rsp_err   = rsp_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= IW'(NREQ - 1);
      gnt_idx_reg   <= '0;
      cnt_reg       <= '0;
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      add_start_reg <= 1'b0;
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
      rsp_inf_reg   <= 1'b0;
      rsp_zero_reg  <= 1'b0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req_valid) begin
            op_a_reg      <= a_slice[arb_index];
            op_b_reg      <= b_slice[arb_index];
            gnt_idx_reg   <= arb_index;
            cnt_reg       <= '0;
            add_start_reg <= 1'b1;
            state_reg     <= WAIT;
          end
        end
        WAIT: begin
          if (add_done) begin
            rsp_data_reg  <= add_out;
            rsp_inf_reg   <= add_inf;
            rsp_zero_reg  <= add_zero;
            rsp_err_reg   <= 1'b0;
            add_start_reg <= 1'b0;
            rsp_valid_reg <= {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx_reg;
            state_reg     <= RESP;
          end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
            // Watchdog: the adder never answered, report NaR with error.
            rsp_data_reg  <= NAR;
            rsp_inf_reg   <= 1'b1;
            rsp_zero_reg  <= 1'b0;
            rsp_err_reg   <= 1'b1;
            add_start_reg <= 1'b0;
            rsp_valid_reg <= {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx_reg;
            state_reg     <= RESP;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        RESP: begin
          rsp_valid_reg <= '0;
          ptr_reg       <= gnt_idx_reg;
          state_reg     <= IDLE;
        end
        default: begin
          add_start_reg <= 1'b0;
          rsp_valid_reg <= '0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_posit_add_sched.sv
// tb_posit_add_sched
//   Randomized bench for posit_add_sched with a behavioural adder stub
//   (configurable done latency, 0 = never answers) and a transaction-level
//   reference model: round-robin pick from the last granted index, expected
//   response delay, and expected result/flags derived from the operands the
//   bench itself drove.
module tb_posit_add_sched;

  localparam int N       = 8;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      req_valid;
  logic [31:0]     req_a;
  logic [31:0]     req_b;
  logic [3:0]      req_ready;
  logic [3:0]      rsp_valid;
  logic [7:0]      rsp_data;
  logic            rsp_inf;
  logic            rsp_zero;
  logic            rsp_err;
  logic [7:0]      add_in1;
  logic [7:0]      add_in2;
  logic            add_start;
  logic [7:0]      add_out;
  logic            add_inf;
  logic            add_zero;
  logic            add_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int stub_lat = 1;
  int st_cnt;
  int model_ptr = NREQ - 1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  posit_add_sched #(
    .N       (N),
    .es      (2),
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_inf   (rsp_inf),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err),
    .add_in1   (add_in1),
    .add_in2   (add_in2),
    .add_start (add_start),
    .add_out   (add_out),
    .add_inf   (add_inf),
    .add_zero  (add_zero),
    .add_done  (add_done)
  );

  // Adder stub: wrapping sum as the result, inf when either operand is NaR,
  // zero when both operands are zero; done after stub_lat start cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_cnt <= 0;
    else        st_cnt <= add_start ? st_cnt + 1 : 0;
  end
  assign add_out  = add_in1 + add_in2;
  assign add_inf  = (add_in1 == 8'h80) || (add_in2 == 8'h80);
  assign add_zero = (add_in1 == 8'h00) && (add_in2 == 8'h00);
  assign add_done = add_start && (stub_lat != 0) && (st_cnt == stub_lat - 1);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [3:0] m);
    for (int i = 1; i <= NREQ; i++) begin
      int j;
      j = (ptr + i) % NREQ;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  // Must be called at a falling edge where the scheduler is in IDLE.
  // Returns at the falling edge of the IDLE cycle after the response.
  task automatic do_txn(input logic [3:0] mask, input logic [31:0] av,
                        input logic [31:0] bv, input int lat, input bit hold,
                        output int acc_cyc);
    int g, k, n;
    bit tmo;
    logic [7:0] ea, eb, ed;
    req_valid = mask;
    req_a     = av;
    req_b     = bv;
    stub_lat  = lat;
    #1;
    g = rr_pick(model_ptr, mask);
    check_eq("req_ready", 32'(req_ready), 32'(4'b0001 << g));
    acc_cyc = cyc;
    ea  = av[g*8 +: 8];
    eb  = bv[g*8 +: 8];
    tmo = (lat == 0) || (lat > TIMEOUT);
    k   = tmo ? TIMEOUT : lat;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (rsp_valid == 4'b0000) begin
        check_eq("wait_start", 32'(add_start), 32'd1);
        check_eq("wait_in1", 32'(add_in1), 32'(ea));
        check_eq("wait_in2", 32'(add_in2), 32'(eb));
        check_eq("wait_ready", 32'(req_ready), 32'd0);
        if (n == 1) req_valid = 4'($urandom);
      end
    end while (rsp_valid == 4'b0000 && n <= TIMEOUT + 4);
    ed = tmo ? 8'h80 : 8'(ea + eb);
    check_eq("rsp_lat", 32'(n), 32'(k + 1));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(4'b0001 << g));
    check_eq("rsp_start_low", 32'(add_start), 32'd0);
    check_eq("rsp_data", 32'(rsp_data), 32'(ed));
    check_eq("rsp_inf", 32'(rsp_inf), tmo ? 32'd1 : 32'((ea == 8'h80) || (eb == 8'h80)));
    check_eq("rsp_zero", 32'(rsp_zero), tmo ? 32'd0 : 32'((ea == 8'h00) && (eb == 8'h00)));
    check_eq("rsp_err", 32'(rsp_err), 32'(tmo));
    $display("[TB] txn mask=%b grant=%0d a=%h b=%h lat=%0d data=%h inf=%0d zero=%0d err=%0d",
             mask, g, ea, eb, lat, rsp_data, rsp_inf, rsp_zero, rsp_err);
    model_ptr = g;
    req_valid = hold ? mask : 4'b0000;
    @(negedge clk);
    check_eq("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    check_eq("rsp_hold", 32'(rsp_data), 32'(ed));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, prev_acc;
    logic [3:0] m;
    req_valid = 4'b0000;
    req_a     = '0;
    req_b     = '0;

    // Reset and idle.
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_start", 32'(add_start), 32'd0);
    check_eq("rst_in1", 32'(add_in1), 32'd0);
    check_eq("rst_in2", 32'(add_in2), 32'd0);
    check_eq("rst_data", 32'(rsp_data), 32'd0);
    check_eq("rst_flags", 32'({rsp_inf, rsp_zero, rsp_err}), 32'd0);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_eq("idle_start", 32'(add_start), 32'd0);
      check_eq("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("idle_ready", 32'(req_ready), 32'd0);
    end

    // Single request from requester 2 with a 3-cycle adder.
    do_txn(4'b0100, 32'h0028_0000, 32'h0039_0000, 3, 1'b0, acc);

    // Fairness: everyone requesting, same-cycle adder.
    prev_acc = 0;
    for (int i = 0; i < 8; i++) begin
      do_txn(4'b1111, $urandom, $urandom, 1, 1'b1, acc);
      if (i > 0) check_eq("rr_spacing", 32'(acc - prev_acc), 32'd3);
      prev_acc = acc;
    end

    // Flags: NaR operand gives inf, 0+0 gives zero.
    do_txn(4'b0001, 32'h0000_0080, 32'h0000_00e5, 2, 1'b0, acc);
    do_txn(4'b1000, 32'h0000_0000, 32'h0000_0000, 1, 1'b0, acc);

    // Timeout: adder never answers.
    do_txn(4'b0001, $urandom, $urandom, 0, 1'b0, acc);

    // Randomized traffic.
    for (int i = 0; i < 25; i++) begin
      int lat;
      do m = 4'($urandom); while (m == 4'b0000);
      lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5));
      do_txn(m, $urandom, $urandom, lat, 1'($urandom_range(0, 1)), acc);
    end

    // Asynchronous reset in the second WAIT cycle.
    req_valid = 4'b0110;
    req_a     = $urandom;
    req_b     = $urandom;
    stub_lat  = 0;
    #1;
    check_eq("mw_ready", 32'(req_ready), 32'(4'b0001 << rr_pick(model_ptr, 4'b0110)));
    @(posedge clk);
    @(posedge clk);
    #2;
    check_eq("mw_start_before", 32'(add_start), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mw_start_async", 32'(add_start), 32'd0);
    check_eq("mw_in1_async", 32'(add_in1), 32'd0);
    check_eq("mw_ready_rst", 32'(req_ready), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check_eq("mw_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    model_ptr = NREQ - 1;
    do_txn(4'b0110, $urandom, $urandom, 2, 1'b0, acc);
    check_eq("mw_ptr_after", 32'(model_ptr), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/posit_add_sched.md
# posit_add_sched

Round-robin scheduler that shares one `posit_adder` instance (N-bit posit, es exponent bits, `start`/`done` handshake) among NREQ requesters. It latches one requester's operand pair and drives the adder, holding `start` until `done`. It then returns the sum with the inf and zero flags to that requester. A watchdog recovers from a missing `done`. It sits between the posit datapath clients and the single adder.

## Interface
- N, 8, posit width
- es, 2, exponent bits (passed through; scheduler is es-agnostic)
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 15, max WAIT cycles before abort (1..255)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_a  in  NREQ*N  operand 1, requester i at [i*N +: N]
- req_b  in  NREQ*N  operand 2, same packing
- req_ready  out  NREQ  one-hot accept strobe
- rsp_valid  out  NREQ  one-hot, one-cycle response strobe
- rsp_data  out  N  sum
- rsp_inf  out  1  adder inf flag, or 1 on timeout
- rsp_zero  out  1  adder zero flag
- rsp_err  out  1  timeout abort
- add_in1, add_in2  out  N  adder operands
- add_start  out  1  adder start
- add_out  in  N  adder result
- add_inf, add_zero, add_done  in  1  adder flags

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if any req_valid, pick grant g = first set bit searching from (ptr+1) mod NREQ upward with wrap. Assert req_ready[g] combinationally in this cycle. At the edge, latch req_a/req_b slice g into operand registers, store g, clear wait counter, go to WAIT. No req_valid: stay in IDLE.
- WAIT: add_start=1; add_in1/add_in2 driven from operand registers (stable throughout).
  - add_done=1: capture add_out, add_inf, add_zero; rsp_err<=0; go to RESP.
  - Else if counter = TIMEOUT-1: rsp_data<=NaR (1 followed by N-1 zeros), rsp_inf<=1, rsp_zero<=0, rsp_err<=1; go to RESP.
  - Else counter+1.
- RESP: rsp_valid[g]=1 for exactly one cycle. ptr<=g. Go to IDLE.
- add_done while add_start=0 is ignored. req_valid changes after the accept cycle are ignored. Other requesters' req_ready stays 0 while busy.
- Result bits pass through unmodified; no width conversion. Counter width is clog2(TIMEOUT+1).

## Timing
- Reset (asynchronous, immediate): state IDLE, ptr=NREQ-1 (requester 0 has first priority), req_ready=0, rsp_valid=0, add_start=0, add_in1/add_in2=0, rsp_data=0, rsp_inf=0, rsp_zero=0, rsp_err=0, counter=0.
- Latency: handshake in cycle c; WAIT in cycles c+1..c+k, with done seen in cycle c+k (k≥1); rsp_valid in cycle c+k+1. With a same-cycle adder (done with start), rsp_valid is at c+2.
- Throughput: next accept is at c+k+2 at the earliest, so one operation per k+2 cycles.
- rsp_data/rsp_inf/rsp_zero/rsp_err hold their values after RESP until the next capture.
- Reset mid-WAIT: add_start drops at once and the request is lost without a response. A requester still holding req_valid is re-arbitrated after reset.
- Timeout: abort after TIMEOUT consecutive WAIT cycles without done; rsp_valid follows in the next cycle.

## Structure
- Package `posit_sched_pkg`: state enum, NaR constant as a function of N, clog2 function.
- Sub-module `rr_arbiter` (NREQ): inputs req and ptr; outputs one-hot grant and index. Purely combinational.
- `posit_adder` is instantiated outside this block and connected via the add_* ports.

## Test plan
- Reset/idle: rst_n low then high, no requests -> all outputs 0, add_start 0 indefinitely.
- Single request: requester 2, a=8'b00101000, b=8'b00111001, adder stub with done latency 3 -> req_ready[2] for one cycle; add_in1/add_in2 equal these operands while add_start=1; rsp_valid[2] 4 cycles after accept; rsp_data = stub output; rsp_err=0.
- Round-robin fairness: all four req_valid held high, same-cycle stub -> grants 0,1,2,3,0… with accepts spaced 3 cycles apart; no requester is granted twice before the others.
- Flags: stub returns inf=1 for a=8'b10000000, b=8'b11100101, and zero=1 for 0+0 -> rsp_inf/rsp_zero mirror the stub, rsp_err=0.
- Timeout: stub never asserts done, TIMEOUT=15 -> add_start high for exactly 15 cycles; rsp_data=8'b10000000, rsp_inf=1, rsp_err=1; scheduler returns to IDLE.
- Async reset mid-WAIT: rst_n low in the second WAIT cycle -> add_start falls without a clock edge; no rsp_valid; after release, the held req_valid[1] is accepted first via ptr reset.
